// File: rtl/packet_scheduler.sv
// packet_scheduler: data-island sequencer and packet arbiter for a TMDS/HDMI encoder.
//
// Ports:
//   clk_pixel          pixel clock, the only clock
//   reset_n            asynchronous active-low reset
//   video_blank        high during blanking
//   blank_remaining    blanking cycles left, including the current cycle
//   req[NUM_REQ]       per-requester "packet pending" level
//   ack[NUM_REQ]       one-cycle pulse on the last cycle of the granted packet
//   packet_sel         requester whose header/subpackets feed the assembler
//   data_island_period high exactly while packet data is being sent
//   mode               00 control, 01 preamble, 10 guard band, 11 packet data
//   overrun            sticky: blanking ended while an island was in flight
//
// Build option: define PACKET_SCHED_RR_EN for round-robin arbitration;
// otherwise arbitration is fixed priority, lowest index first.
module packet_scheduler #(
    parameter int NUM_REQ     = 4,
    parameter int MAX_PACKETS = 18
) (
    input  logic               clk_pixel,
    input  logic               reset_n,
    input  logic               video_blank,
    input  logic [11:0]        blank_remaining,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic [2:0]         packet_sel,
    output logic               data_island_period,
    output logic [1:0]         mode,
    output logic               overrun
);
    typedef enum logic [2:0] {IDLE, PREAMBLE, LEAD_GUARD, PACKET, TRAIL_GUARD} state_t;
    state_t      state;
    logic [2:0]  phase_cnt;
    logic [4:0]  pkt_cnt;
    logic [4:0]  pkt_num;
    logic [7:0]  req_w;
    logic [7:0]  elig;
    logic [2:0]  arb_start;
    logic [2:0]  win;
    logic [3:0]  idx;
    logic        found;
    logic        start_ok;
    logic        cont_ok;

    assign req_w = 8'(req);
    // The packet being acked this cycle must not win again immediately.
    assign elig     = (state == PACKET) ? (req_w & ~(8'd1 << packet_sel)) : req_w;
    // 8 preamble + 2 guard + 32 packet + 2 guard + 12 control + 1
    assign start_ok = video_blank && |req && blank_remaining >= 12'd57;
    // 32 packet + 2 guard + 12 control + 1
    assign cont_ok  = found && pkt_num < 5'(MAX_PACKETS) && blank_remaining >= 12'd47;

`ifdef PACKET_SCHED_RR_EN
    logic [2:0] rr_ptr;
    logic [2:0] nxt_sel;
    assign nxt_sel   = (packet_sel == 3'(NUM_REQ - 1)) ? 3'd0 : packet_sel + 3'd1;
    // rr_ptr holds the first index to search; at an ack it is being updated
    // to nxt_sel in the same cycle, so search from nxt_sel directly.
    assign arb_start = (state == PACKET) ? nxt_sel : rr_ptr;
    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n)
            rr_ptr <= '0;
        else if (state == PACKET && pkt_cnt == 5'd31)
            rr_ptr <= nxt_sel;
    end
`else
    assign arb_start = '0;
`endif

    // Rotating search from arb_start; wraps at NUM_REQ so the winner is always in range.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = 4'(arb_start) + 4'(i);
            idx = (idx >= 4'(NUM_REQ)) ? idx - 4'(NUM_REQ) : idx;
            if (!found && elig[idx[2:0]]) begin
                found = 1'b1;
                win   = idx[2:0];
            end
        end
    end

    always_ff @(posedge clk_pixel or negedge reset_n) begin
        if (!reset_n) begin
            state              <= IDLE;
            phase_cnt          <= '0;
            pkt_cnt            <= '0;
            pkt_num            <= '0;
            ack                <= '0;
            packet_sel         <= '0;
            data_island_period <= 1'b0;
            mode               <= 2'b00;
            overrun            <= 1'b0;
        end else begin
            ack <= '0;
            if (state != IDLE && !video_blank)
                overrun <= 1'b1;
            case (state)
                IDLE: if (start_ok) begin
                    state     <= PREAMBLE;
                    mode      <= 2'b01;
                    phase_cnt <= '0;
                end
                PREAMBLE: if (phase_cnt == 3'd7) begin
                    state     <= LEAD_GUARD;
                    mode      <= 2'b10;
                    phase_cnt <= '0;
                end else begin
                    phase_cnt <= phase_cnt + 3'd1;
                end
                LEAD_GUARD: if (phase_cnt == 3'd1) begin
                    state              <= PACKET;
                    mode               <= 2'b11;
                    data_island_period <= 1'b1;
                    pkt_cnt            <= '0;
                    pkt_num            <= 5'd1;
                    packet_sel         <= win;
                end else begin
                    phase_cnt <= phase_cnt + 3'd1;
                end
                PACKET: begin
                    pkt_cnt <= pkt_cnt + 5'd1;
                    // Registered ack lands on the cycle where pkt_cnt is 31.
                    if (pkt_cnt == 5'd30)
                        ack <= NUM_REQ'(8'd1 << packet_sel);
                    if (pkt_cnt == 5'd31) begin
                        if (cont_ok) begin
                            pkt_num    <= pkt_num + 5'd1;
                            packet_sel <= win;
                        end else begin
                            state              <= TRAIL_GUARD;
                            mode               <= 2'b10;
                            data_island_period <= 1'b0;
                            phase_cnt          <= '0;
                        end
                    end
                end
                TRAIL_GUARD: if (phase_cnt == 3'd1) begin
                    state <= IDLE;
                    mode  <= 2'b00;
                end else begin
                    phase_cnt <= phase_cnt + 3'd1;
                end
                default: begin
                    state              <= IDLE;
                    mode               <= 2'b00;
                    data_island_period <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_packet_scheduler.sv
// tb_packet_scheduler: directed checks of packet_scheduler in its default (fixed-priority) build.
module tb_packet_scheduler;
    logic        clk_pixel = 1'b0;
    logic        reset_n;
    logic        video_blank;
    logic [11:0] blank_remaining;
    logic [3:0]  req;
    logic [3:0]  ack;
    logic [2:0]  packet_sel;
    logic        data_island_period;
    logic [1:0]  mode;
    logic        overrun;
    int          n_cmp = 0;
    int          n_err = 0;

    packet_scheduler dut (
        .clk_pixel          (clk_pixel),
        .reset_n            (reset_n),
        .video_blank        (video_blank),
        .blank_remaining    (blank_remaining),
        .req                (req),
        .ack                (ack),
        .packet_sel         (packet_sel),
        .data_island_period (data_island_period),
        .mode               (mode),
        .overrun            (overrun)
    );

    always #5 clk_pixel = ~clk_pixel;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk_pixel);
        #1;
    endtask

    function automatic logic [1:0] exp_mode(input int k);
        return (k <= 8) ? 2'b01 : (k <= 10) ? 2'b10 : (k <= 42) ? 2'b11 : (k <= 44) ? 2'b10 : 2'b00;
    endfunction

    initial begin
        reset_n = 1'b0; video_blank = 1'b0; blank_remaining = '0; req = '0;
        tick(2);
        chk("rst_mode", mode, 2'b00);
        chk("rst_ack", ack, 4'b0000);
        chk("rst_sel", packet_sel, 3'd0);
        chk("rst_dip", data_island_period, 1'b0);
        chk("rst_ovr", overrun, 1'b0);
        reset_n = 1'b1;

        // 56 cycles of blanking is one too few for an island
        video_blank = 1'b1; req = 4'b0001; blank_remaining = 12'd56;
        tick(5);
        chk("br56_mode", mode, 2'b00);

        // single packet island, req withdrawn mid-packet
        blank_remaining = 12'd57;
        for (int k = 1; k <= 46; k++) begin
            tick();
            if (k == 20) req = 4'b0000;
            chk($sformatf("one_mode_%0d", k), mode, exp_mode(k));
            chk($sformatf("one_ack_%0d", k), ack, (k == 42) ? 4'b0001 : 4'b0000);
            chk($sformatf("one_dip_%0d", k), data_island_period, (k >= 11 && k <= 42) ? 1'b1 : 1'b0);
        end
        chk("one_sel", packet_sel, 3'd0);

        // all requesting: 18 packets alternating 0,1 then trail guard
        req = 4'b1111; blank_remaining = 12'd1000;
        tick(10);
        chk("full_lg", mode, 2'b10);
        for (int n = 0; n < 18; n++) begin
            tick();
            chk($sformatf("full_sel_%0d", n), packet_sel, 3'(n % 2));
            chk($sformatf("full_mode_%0d", n), mode, 2'b11);
            tick(30);
            chk($sformatf("full_noack_%0d", n), ack, 4'b0000);
            tick();
            chk($sformatf("full_ack_%0d", n), ack, 4'(1 << (n % 2)));
        end
        tick();
        chk("full_trail", mode, 2'b10);
        req = 4'b0000;
        tick(2);
        chk("full_idle", mode, 2'b00);

        // blank_remaining 47 at pkt_cnt 31 continues, 46 ends the island
        req = 4'b0011; blank_remaining = 12'd57;
        tick(10);
        blank_remaining = 12'd47;
        tick(32);
        chk("b47_ack0", ack, 4'b0001);
        tick();
        chk("b47_mode", mode, 2'b11);
        chk("b47_sel", packet_sel, 3'd1);
        blank_remaining = 12'd46;
        tick(31);
        chk("b47_ack1", ack, 4'b0010);
        tick();
        chk("b46_trail", mode, 2'b10);
        req = 4'b0000;
        tick(2);
        chk("b46_idle", mode, 2'b00);

        req = 4'b0011; blank_remaining = 12'd57;
        tick(10);
        blank_remaining = 12'd46;
        tick(32);
        chk("b46_ack", ack, 4'b0001);
        tick();
        chk("b46_first_trail", mode, 2'b10);
        req = 4'b0000;
        tick(2);
        chk("b46_first_idle", mode, 2'b00);

        // blanking ends during the third packet
        req = 4'b1111; blank_remaining = 12'd1000;
        tick(79);
        chk("ovr_pre", overrun, 1'b0);
        chk("ovr_p3_sel", packet_sel, 3'd0);
        video_blank = 1'b0; req = 4'b0000;
        tick();
        chk("ovr_set", overrun, 1'b1);
        chk("ovr_mode", mode, 2'b11);
        tick(26);
        chk("ovr_ack", ack, 4'b0001);
        tick();
        chk("ovr_trail", mode, 2'b10);
        tick(2);
        chk("ovr_idle", mode, 2'b00);
        tick(3);
        chk("ovr_sticky", overrun, 1'b1);

        // reset in the middle of a packet
        video_blank = 1'b1; req = 4'b0001; blank_remaining = 12'd57;
        tick(21);
        chk("mid_dip", data_island_period, 1'b1);
        reset_n = 1'b0;
        #2;
        chk("mid_rst_mode", mode, 2'b00);
        chk("mid_rst_dip", data_island_period, 1'b0);
        chk("mid_rst_sel", packet_sel, 3'd0);
        chk("mid_rst_ovr", overrun, 1'b0);
        chk("mid_rst_ack", ack, 4'b0000);
        tick(3);
        chk("mid_rst_ack2", ack, 4'b0000);
        reset_n = 1'b1;
        for (int k = 1; k <= 44; k++) begin
            tick();
            if (k == 20) req = 4'b0000;
            chk($sformatf("re_mode_%0d", k), mode, exp_mode(k));
            chk($sformatf("re_ack_%0d", k), ack, (k == 42) ? 4'b0001 : 4'b0000);
        end
        tick();
        chk("re_idle", mode, 2'b00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/packet_scheduler.md
PACKET_SCHEDULER -- requirements
Module: packet_scheduler

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of packet requesters, range 1..8.
REQ-002 SHALL have parameter MAX_PACKETS, default 18: maximum packets per data island, range 1..18.
REQ-003 SHALL have port clk_pixel  in  1  pixel clock; the only clock.
REQ-004 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-005 SHALL have port video_blank  in  1  high during blanking.
REQ-006 SHALL have port blank_remaining  in  12  blanking cycles left, including the current cycle.
REQ-007 SHALL have port req  in  NUM_REQ  per-requester "packet pending" level.
REQ-008 SHALL have port ack  out  NUM_REQ  one-cycle pulse: the granted packet has been sent.
REQ-009 SHALL have port packet_sel  out  3  index of the requester whose header/subpackets are muxed to the packet assembler.
REQ-010 SHALL have port data_island_period  out  1  drives the assembler's data_island_period.
REQ-011 SHALL have port mode  out  2  encoding: 00 control, 01 data-island preamble, 10 guard band, 11 packet data.
REQ-012 SHALL have port overrun  out  1  sticky error flag.

Function
REQ-013 SHALL implement the FSM states IDLE, PREAMBLE, LEAD_GUARD, PACKET and TRAIL_GUARD; mode SHALL be 00/01/10/11/10 in these states respectively.
REQ-014 IDLE->PREAMBLE SHALL occur when video_blank=1, |req=1 and blank_remaining>=57 (8 preamble + 2 guard + 32 packet + 2 guard + 12 control + 1).
REQ-015 PREAMBLE SHALL last exactly 8 cycles, then go to LEAD_GUARD, which SHALL last exactly 2 cycles, then go to PACKET.
REQ-016 PACKET SHALL last exactly 32 cycles per packet, counted by an internal 5-bit counter (pkt_cnt) that is 0 on the first cycle of each packet.
REQ-017 data_island_period SHALL be 1 exactly in the PACKET state, so the assembler's 32-cycle counter stays aligned to packet boundaries.
REQ-018 Arbitration SHALL occur on the last LEAD_GUARD cycle and on pkt_cnt=31; packet_sel SHALL be registered and SHALL take the new value on the first cycle of the next packet.
REQ-019 On pkt_cnt=31, ack[packet_sel] SHALL pulse for that single cycle.
REQ-020 Arbitration SHALL ignore req[packet_sel] on the same cycle its ack is pulsed, so the same packet is never resent back-to-back.
REQ-021 At pkt_cnt=31 the FSM SHALL stay in PACKET (new packet) if an eligible req exists, packets sent <MAX_PACKETS and blank_remaining>=47; otherwise it SHALL go to TRAIL_GUARD.
REQ-022 TRAIL_GUARD SHALL last exactly 2 cycles, then return to IDLE.
REQ-023 A new island SHALL NOT start in the same blanking interval unless REQ-014 holds again after TRAIL_GUARD.
REQ-024 If req drops for the selected requester mid-packet, the packet SHALL complete and ack SHALL still pulse.
REQ-025 If video_blank=0 in any state other than IDLE, the island SHALL complete unchanged and overrun SHALL set and remain 1 until reset.
REQ-026 When NUM_REQ<8, packet_sel SHALL never exceed NUM_REQ-1.

Reset
REQ-027 Asserting reset_n=0 at any time SHALL immediately force state IDLE and pkt_cnt=0, packet count=0, ack=0, packet_sel=0, data_island_period=0, mode=00, overrun=0, and the round-robin pointer=0.
REQ-028 Reset mid-island SHALL abandon the island with no ack; the top level SHALL drive the assembler reset from the same source so both counters restart at 0.
REQ-029 Deassertion of reset_n SHALL be synchronised externally; the first active edge after deassertion SHALL evaluate IDLE.

Configuration
REQ-030 With the macro PACKET_SCHED_RR_EN defined, arbitration SHALL be round-robin: search starts at the index after the last granted one, and the pointer updates on each ack.
REQ-031 With PACKET_SCHED_RR_EN undefined, arbitration SHALL be fixed priority, lowest index first; all other behaviour SHALL be identical.

Verification
REQ-032 req=0001, blank_remaining=57 with video_blank=1 -> 8 preamble, 2 guard, 32 packet with packet_sel=0, ack[0] at cycle 32 of the packet, 2 guard, IDLE; 44 cycles total.
REQ-033 blank_remaining=56 with req pending -> no island is started (mode stays 00).
REQ-034 req=1111 held with ample blanking -> 18 consecutive packets, then TRAIL_GUARD; with RR the grant order is 0,1,2,3,0,...; with fixed priority it is 0,1,0,1,... (ack exclusion).
REQ-035 req=0011 with blank_remaining=47 at the first pkt_cnt=31 -> second packet sent; with blank_remaining=46 -> TRAIL_GUARD instead.
REQ-036 video_blank dropped during the 3rd packet -> island completes, overrun=1 and stays 1.
REQ-037 reset_n pulsed low during pkt_cnt=10 -> all outputs zero immediately, no ack; the next island starts cleanly from PREAMBLE.
